window_line_buffer: RTL and testbench

- Streaming producer of the KERNEL_SIZE x KERNEL_SIZE pixel window consumed by kernel_convolution.
- Accepts raster-order packed RGB pixels, one per valid cycle, and stores KERNEL_SIZE-1 full lines in line buffers.
- Presents a registered sliding window plus a valid strobe and window coordinates.
- Sits between the pixel source (camera/frame reader) and the convolution array.

---
 rtl/window_line_buffer.sv | 161 ++++++++++++++++
 tb/tb_window_line_buffer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/window_line_buffer.sv
// window_line_buffer
//   Streaming producer of the KERNEL_SIZE x KERNEL_SIZE pixel window that
//   feeds kernel_convolution. Raster-order pixels are written into
//   KERNEL_SIZE-1 cascaded line buffers. A registered sliding window is
//   presented together with a valid strobe and the top-left coordinate of
//   the window.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for sof; valid pixels without sof are dropped
//   ACTIVE | accepting every valid pixel of the current frame
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   pixel_in     raster-order packed pixel {r,g,b}
//   pixel_valid  pixel_in is valid this cycle
//   sof          start of frame, qualified by pixel_valid
//   window_out   [row][col] window, row 0 = oldest line, col 0 = oldest column
//   window_valid one-cycle strobe: window_out holds a new in-image window
//   out_x/out_y  top-left coordinate of the current window
//   frame_done   one-cycle pulse with the last window of a frame
//   busy         high while in ACTIVE
//   drop_err     one-cycle pulse when a pixel is dropped in IDLE
module window_line_buffer #(
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int PIXEL_W     = 48,
  localparam int XW = $clog2(IMG_WIDTH),
  localparam int YW = $clog2(IMG_HEIGHT)
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic [PIXEL_W-1:0]                                pixel_in,
  input  logic                                              pixel_valid,
  input  logic                                              sof,
  output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PIXEL_W-1:0] window_out,
  output logic                                              window_valid,
  output logic [XW-1:0]                                     out_x,
  output logic [YW-1:0]                                     out_y,
  output logic                                              frame_done,
  output logic                                              busy,
  output logic                                              drop_err
);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] X_K1   = XW'(KERNEL_SIZE - 1);
  localparam logic [YW-1:0] Y_K1   = YW'(KERNEL_SIZE - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t                                              r_state;
  logic [XW-1:0]                                       r_x;
  logic [YW-1:0]                                       r_y;
  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PIXEL_W-1:0] r_win;
  logic                                                r_valid;
  logic [XW-1:0]                                       r_out_x;
  logic [YW-1:0]                                       r_out_y;
  logic                                                r_fd;
  logic                                                r_busy;
  logic                                                r_drop;

  // Buffer 0 holds the oldest line, buffer KERNEL_SIZE-2 the newest.
  logic [PIXEL_W-1:0] r_line [KERNEL_SIZE-1][IMG_WIDTH];

  logic                w_accept;
  logic [XW-1:0]       w_x;
  logic [YW-1:0]       w_y;
  logic                w_x_wrap;
  logic                w_last;
  logic                w_win_ok;
  logic [XW-1:0]       w_x_next;
  logic [YW-1:0]       w_y_next;
  logic [PIXEL_W-1:0]  w_col [KERNEL_SIZE-1];

  // An sof pixel is always (0,0), even when it aborts a frame in flight.
  always_comb begin
    w_accept = pixel_valid & (sof | (r_state == S_ACTIVE));
    w_x      = sof ? '0 : r_x;
    w_y      = sof ? '0 : r_y;
    w_x_wrap = (w_x == X_LAST);
    w_last   = w_x_wrap && (w_y == Y_LAST);
    w_win_ok = (w_x >= X_K1) && (w_y >= Y_K1);
    w_x_next = w_x_wrap ? '0 : w_x + XW'(1);
    w_y_next = w_y;
    if (w_x_wrap) begin
      w_y_next = (w_y == Y_LAST) ? '0 : w_y + YW'(1);
    end
  end

  always_comb begin
    for (int k = 0; k < KERNEL_SIZE - 1; k++) begin
      w_col[k] = r_line[k][w_x];
    end
  end

  // Line buffers are not reset; NBA gives read-before-write at column w_x.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_line[KERNEL_SIZE-2][w_x] <= pixel_in;
      for (int k = 1; k < KERNEL_SIZE - 1; k++) begin
        r_line[k-1][w_x] <= r_line[k][w_x];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_win   <= '0;
      r_valid <= 1'b0;
      r_out_x <= '0;
      r_out_y <= '0;
      r_fd    <= 1'b0;
      r_busy  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_fd    <= 1'b0;
      r_drop  <= pixel_valid & ~sof & (r_state == S_IDLE);
      if (w_accept) begin
        r_x     <= w_x_next;
        r_y     <= w_y_next;
        r_state <= w_last ? S_IDLE : S_ACTIVE;
        r_busy  <= ~w_last;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
          for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
            r_win[r][c] <= r_win[r][c+1];
          end
        end
        for (int r = 0; r < KERNEL_SIZE - 1; r++) begin
          r_win[r][KERNEL_SIZE-1] <= w_col[r];
        end
        r_win[KERNEL_SIZE-1][KERNEL_SIZE-1] <= pixel_in;
        // Windows that straddle a line wrap or the frame top are never flagged.
        r_valid <= w_win_ok;
        r_fd    <= w_last;
        if (w_win_ok) begin
          r_out_x <= w_x - X_K1;
          r_out_y <= w_y - Y_K1;
        end
      end
    end
  end

  assign window_out   = r_win;
  assign window_valid = r_valid;
  assign out_x        = r_out_x;
  assign out_y        = r_out_y;
  assign frame_done   = r_fd;
  assign busy         = r_busy;
  assign drop_err     = r_drop;

endmodule

// File: tb/tb_window_line_buffer.sv
// Scoreboard bench for window_line_buffer with an 8x6 frame and a 3x3 kernel.
module tb_window_line_buffer;
  localparam int K  = 3;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = 48;
  localparam int NWIN = (W - K + 1) * (H - K + 1);

  typedef logic [K-1:0][K-1:0][PW-1:0] win_t;
  typedef struct {
    win_t       win;
    logic [2:0] x;
    logic [2:0] y;
    logic       fd;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [PW-1:0] pixel_in = '0;
  logic          pixel_valid = 1'b0;
  logic          sof = 1'b0;
  win_t          window_out;
  logic          window_valid;
  logic [2:0]    out_x;
  logic [2:0]    out_y;
  logic          frame_done;
  logic          busy;
  logic          drop_err;

  exp_t sb_q[$];
  exp_t e_mon;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_win = 0;
  int   n_fd = 0;
  int   n_drop = 0;

  window_line_buffer #(
    .KERNEL_SIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_W(PW)
  ) dut (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .sof(sof), .window_out(window_out), .window_valid(window_valid),
    .out_x(out_x), .out_y(out_y), .frame_done(frame_done), .busy(busy),
    .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // g carries the frame tag so stale data from another frame is visible.
  function automatic logic [PW-1:0] pix(input int tag, input int x, input int y);
    return {16'd0, 16'(tag), 16'(y * W + x)};
  endfunction

  task automatic push_exp(input int tag, input int x, input int y);
    exp_t e;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        e.win[r][c] = pix(tag, x - (K - 1) + c, y - (K - 1) + r);
    e.x  = 3'(x - (K - 1));
    e.y  = 3'(y - (K - 1));
    e.fd = (x == W - 1) && (y == H - 1);
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic s, input logic [PW-1:0] d);
    @(negedge clk);
    pixel_valid = v;
    sof = s;
    pixel_in = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0);
  endtask

  task automatic send_frame(input int tag, input int npix, input bit gaps);
    win_t       snap;
    logic [2:0] sx, sy;
    for (int i = 0; i < npix; i++) begin
      int x = i % W;
      int y = i / W;
      drive(1'b1, i == 0, pix(tag, x, y));
      if (x >= K - 1 && y >= K - 1) push_exp(tag, x, y);
      if (i == 1) chk_val("busy_active", 512'(busy), 512'(1));
      if (gaps && $urandom_range(0, 1) == 1) begin
        int n = $urandom_range(2, 3);
        for (int g = 0; g < n; g++) begin
          @(negedge clk);
          if (g == 0) begin
            pixel_valid = 1'b0;
            sof = 1'b0;
            snap = window_out;
            sx = out_x;
            sy = out_y;
          end else begin
            chk_val("gap_window", 512'(window_out), 512'(snap));
            chk_val("gap_xy", 512'({out_x, out_y}), 512'({sx, sy}));
          end
        end
      end
    end
  endtask

  task automatic drain();
    int budget = 20;
    while (sb_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk_val("sb_empty", 512'(sb_q.size()), 512'(0));
  endtask

  task automatic chk_zero(input string tag);
    chk_val({tag, "_win"}, 512'(window_out), 512'(0));
    chk_val({tag, "_flags"}, 512'({window_valid, frame_done, busy, drop_err}), 512'(0));
    chk_val({tag, "_xy"}, 512'({out_x, out_y}), 512'(0));
  endtask

  always @(negedge clk) begin
    if (drop_err) n_drop++;
    if (frame_done) n_fd++;
    if (window_valid) begin
      n_win++;
      if (sb_q.size() == 0) begin
        chk_val("sb_underflow", 512'(sb_q.size()), 512'(1));
      end else begin
        e_mon = sb_q.pop_front();
        chk_val("window", 512'(window_out), 512'(e_mon.win));
        chk_val("out_x", 512'(out_x), 512'(e_mon.x));
        chk_val("out_y", 512'(out_y), 512'(e_mon.y));
        chk_val("frame_done", 512'(frame_done), 512'(e_mon.fd));
      end
    end else if (frame_done) begin
      chk_val("fd_without_wv", 512'(window_valid), 512'(1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, fb, db;
    #1;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    // continuous frame
    wb = n_win; fb = n_fd;
    send_frame(1, W * H, 1'b0);
    idle(2);
    drain();
    chk_val("t1_windows", 512'(n_win - wb), 512'(NWIN));
    chk_val("t1_frame_done", 512'(n_fd - fb), 512'(1));
    chk_val("t1_busy_after", 512'(busy), 512'(0));

    // gapped frame
    wb = n_win; fb = n_fd;
    send_frame(2, W * H, 1'b1);
    idle(2);
    drain();
    chk_val("t2_windows", 512'(n_win - wb), 512'(NWIN));
    chk_val("t2_frame_done", 512'(n_fd - fb), 512'(1));

    // abort at pixel index 30 then full frame
    wb = n_win; fb = n_fd;
    send_frame(3, 30, 1'b0);
    send_frame(4, W * H, 1'b0);
    idle(2);
    drain();
    chk_val("t3_windows", 512'(n_win - wb), 512'(10 + NWIN));
    chk_val("t3_frame_done", 512'(n_fd - fb), 512'(1));

    // drops in IDLE
    wb = n_win; db = n_drop;
    repeat (3) begin
      drive(1'b1, 1'b0, pix(15, 0, 0));
      chk_val("t4_busy", 512'(busy), 512'(0));
    end
    idle(2);
    chk_val("t4_drops", 512'(n_drop - db), 512'(3));
    chk_val("t4_no_window", 512'(n_win - wb), 512'(0));
    wb = n_win;
    send_frame(5, W * H, 1'b0);
    idle(2);
    drain();
    chk_val("t4_windows", 512'(n_win - wb), 512'(NWIN));

    // asynchronous reset mid-cycle at pixel index 25
    send_frame(6, 26, 1'b0);
    #2;
    chk_val("t5_busy_before", 512'(busy), 512'(1));
    reset = 1'b0;
    #1;
    chk_zero("t5_async");
    pixel_valid = 1'b0;
    sof = 1'b0;
    idle(2);
    chk_val("t5_sb_empty", 512'(sb_q.size()), 512'(0));
    reset = 1'b1;
    idle(1);
    wb = n_win; fb = n_fd;
    send_frame(7, W * H, 1'b0);
    idle(2);
    drain();
    chk_val("t5_windows", 512'(n_win - wb), 512'(NWIN));
    chk_val("t5_frame_done", 512'(n_fd - fb), 512'(1));

    // back-to-back frames
    wb = n_win; fb = n_fd;
    send_frame(8, W * H, 1'b0);
    send_frame(9, W * H, 1'b0);
    idle(2);
    drain();
    chk_val("t6_windows", 512'(n_win - wb), 512'(2 * NWIN));
    chk_val("t6_frame_done", 512'(n_fd - fb), 512'(2));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
